// File: rtl/ad_frame_unpack.sv
// Receive-side deserializer: reassembles four consecutive 32-bit words into
// four parallel channel samples, flags malformed frames and counts frames/errors.
module ad_frame_unpack #(
  parameter int DW     = 12,
  parameter int FCNT_W = 16,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       ad_ch_in,
  input  logic              valid,
  output logic [DW-1:0]     ch_a,
  output logic [DW-1:0]     ch_b,
  output logic [DW-1:0]     ch_c,
  output logic [DW-1:0]     ch_d,
  output logic              done,
  output logic              pad_err,
  output logic              short_err,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [ECNT_W-1:0] err_cnt
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [DW-1:0]       shadow_q [3];
  logic [DW-1:0]       shadow_d [3];
  logic                pad_q, pad_d;
  logic [DW-1:0]       ch_a_q, ch_a_d;
  logic [DW-1:0]       ch_b_q, ch_b_d;
  logic [DW-1:0]       ch_c_q, ch_c_d;
  logic [DW-1:0]       ch_d_q, ch_d_d;
  logic                done_q, done_d;
  logic                pad_err_q, pad_err_d;
  logic                short_err_q, short_err_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [ECNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [DW-1:0]       payload;
  logic                word_pad;
  logic                last_word;
  logic                abort;
  logic                frame_pad;
  logic                err_inc;

  assign payload   = ad_ch_in[DW-1:0];
  assign word_pad  = |ad_ch_in[31:DW];
  assign last_word = (state_q == COLLECT) && valid && (idx_q == 2'd3);
  assign abort     = (state_q == COLLECT) && !valid;
  assign frame_pad = pad_q | word_pad;
  assign err_inc   = abort || (last_word && frame_pad);

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      // NOTE: the shadow words are reset too, so a frame can never expose stale data.
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
      pad_q       <= 1'b0;
      ch_a_q      <= '0;
      ch_b_q      <= '0;
      ch_c_q      <= '0;
      ch_d_q      <= '0;
      done_q      <= 1'b0;
      pad_err_q   <= 1'b0;
      short_err_q <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
      pad_q       <= pad_d;
      ch_a_q      <= ch_a_d;
      ch_b_q      <= ch_b_d;
      ch_c_q      <= ch_c_d;
      ch_d_q      <= ch_d_d;
      done_q      <= done_d;
      pad_err_q   <= pad_err_d;
      short_err_q <= short_err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = COLLECT;
          idx_d   = 2'd1;
        end
      end
      COLLECT: begin
        if (!valid || idx_q == 2'd3) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    for (int i = 0; i < 3; i++) shadow_d[i] = shadow_q[i];
    pad_d       = pad_q;
    ch_a_d      = ch_a_q;
    ch_b_d      = ch_b_q;
    ch_c_d      = ch_c_q;
    ch_d_d      = ch_d_q;
    done_d      = 1'b0;
    pad_err_d   = 1'b0;
    short_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (valid && idx_q != 2'd3) begin
      for (int i = 0; i < 3; i++) begin
        if (idx_q == 2'(i)) shadow_d[i] = payload;
      end
    end

    // The pad flag restarts with word 0, whichever state accepts it.
    if (valid) begin
      pad_d = (state_q == IDLE) ? word_pad : frame_pad;
    end

    // The fourth word goes straight to ch_d; shadow only holds words 0..2.
    if (last_word) begin
      ch_a_d      = shadow_q[0];
      ch_b_d      = shadow_q[1];
      ch_c_d      = shadow_q[2];
      ch_d_d      = payload;
      done_d      = 1'b1;
      pad_err_d   = frame_pad;
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    if (abort) begin
      short_err_d = 1'b1;
      pad_d       = 1'b0;
    end

    if (err_inc && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + ECNT_W'(1);
    end
  end

  assign ch_a      = ch_a_q;
  assign ch_b      = ch_b_q;
  assign ch_c      = ch_c_q;
  assign ch_d      = ch_d_q;
  assign done      = done_q;
  assign pad_err   = pad_err_q;
  assign short_err = short_err_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ad_frame_unpack.sv
// Self-checking bench for ad_frame_unpack: table-driven frames plus hand-written
// corner sequences, with expected pulses queued at drive time and popped on output.
module tb_ad_frame_unpack;

  localparam int DW = 12;
  localparam int FW = 10;  // narrowed frame counter so the wrap is reachable quickly
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   ad_ch_in = '0;
  logic          valid = 1'b0;
  logic [DW-1:0] ch_a, ch_b, ch_c, ch_d;
  logic          done, pad_err, short_err;
  logic [FW-1:0] frame_cnt;
  logic [EW-1:0] err_cnt;

  ad_frame_unpack #(.DW(DW), .FCNT_W(FW), .ECNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .ad_ch_in(ad_ch_in), .valid(valid),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d),
    .done(done), .pad_err(pad_err), .short_err(short_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] w;
    int               n;
    logic [11:0]      ea, eb, ec, ed;
    bit               epad;
  } vec_t;

  typedef struct {
    bit          is_short;
    logic [11:0] a, b, c, d;
    bit          pad;
    logic [FW-1:0] fcnt;
    logic [EW-1:0] ecnt;
  } exp_t;

  exp_t          exp_q[$];
  int            done_cyc[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic [11:0]   m_ch [4];
  logic [FW-1:0] m_fcnt = '0;
  logic [EW-1:0] m_ecnt = '0;
  vec_t          vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every done/short_err pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (done || short_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", {30'd0, done, short_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (done) done_cyc.push_back(cyc);
        check("short_err", short_err, e.is_short);
        check("done", done, !e.is_short);
        check("ch_a", ch_a, e.a);
        check("ch_b", ch_b, e.b);
        check("ch_c", ch_c, e.c);
        check("ch_d", ch_d, e.d);
        check("pad_err", pad_err, e.is_short ? 1'b0 : e.pad);
        check("frame_cnt", frame_cnt, e.fcnt);
        check("err_cnt", err_cnt, e.ecnt);
      end
    end
  end

  task automatic err_inc();
    if (m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
  endtask

  // Drives n words; queues the expected pulse. Short frames always end with a gap.
  task automatic send(input logic [3:0][31:0] w, input int n, input bit gap,
                      input logic [11:0] ea, eb, ec, ed, input bit epad);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid    = 1'b1;
      ad_ch_in = w[i];
    end
    if (n == 4) begin
      m_fcnt = m_fcnt + 1'b1;
      if (epad) err_inc();
      m_ch[0] = ea; m_ch[1] = eb; m_ch[2] = ec; m_ch[3] = ed;
      e = '{is_short: 1'b0, a: ea, b: eb, c: ec, d: ed, pad: epad,
            fcnt: m_fcnt, ecnt: m_ecnt};
      exp_q.push_back(e);
    end else begin
      err_inc();
      e = '{is_short: 1'b1, a: m_ch[0], b: m_ch[1], c: m_ch[2], d: m_ch[3],
            pad: 1'b0, fcnt: m_fcnt, ecnt: m_ecnt};
      exp_q.push_back(e);
    end
    if (gap || n < 4) begin
      @(negedge clk);
      valid    = 1'b0;
      ad_ch_in = 'x;
    end
  endtask

  task automatic send_plain(input logic [3:0][31:0] w, input bit gap);
    send(w, 4, gap, w[0][11:0], w[1][11:0], w[2][11:0], w[3][11:0], 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0][31:0] w;
    int n_wrap;

    vecs[0] = '{w: {32'h0ABC, 32'h0789, 32'h0456, 32'h0123}, n: 4,
                ea: 12'h123, eb: 12'h456, ec: 12'h789, ed: 12'hABC, epad: 1'b0};
    vecs[1] = '{w: {32'h0, 32'h0, 32'h0222, 32'h0111}, n: 2,
                ea: 12'h123, eb: 12'h456, ec: 12'h789, ed: 12'hABC, epad: 1'b0};
    vecs[2] = '{w: {32'h000D, 32'h000C, 32'h000B, 32'h000A}, n: 4,
                ea: 12'h00A, eb: 12'h00B, ec: 12'h00C, ed: 12'h00D, epad: 1'b0};
    vecs[3] = '{w: {32'h0987, 32'h0001_0FFF, 32'h0654, 32'h0321}, n: 4,
                ea: 12'h321, eb: 12'h654, ec: 12'hFFF, ed: 12'h987, epad: 1'b1};
    vecs[4] = '{w: {32'h0008, 32'h0007, 32'h0006, 32'h8000_0005}, n: 4,
                ea: 12'h005, eb: 12'h006, ec: 12'h007, ed: 12'h008, epad: 1'b1};
    vecs[5] = '{w: {32'h0, 32'h0, 32'h0, 32'h0001_0000}, n: 1,
                ea: 12'h005, eb: 12'h006, ec: 12'h007, ed: 12'h008, epad: 1'b0};
    vecs[6] = '{w: {32'h0, 32'h0333, 32'h0222, 32'h0111}, n: 3,
                ea: 12'h005, eb: 12'h006, ec: 12'h007, ed: 12'h008, epad: 1'b0};
    vecs[7] = '{w: {32'h0001, 32'h0800, 32'h0000, 32'h0FFF}, n: 4,
                ea: 12'hFFF, eb: 12'h000, ec: 12'h800, ed: 12'h001, epad: 1'b0};
    for (int i = 0; i < 4; i++) m_ch[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ch_a", ch_a, 0);
    check("rst_ch_d", ch_d, 0);
    check("rst_flags", {done, pad_err, short_err}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].w, vecs[i].n, 1'b1, vecs[i].ea, vecs[i].eb, vecs[i].ec,
           vecs[i].ed, vecs[i].epad);
      @(negedge clk);
    end
    drain();

    // Back-to-back: three frames on twelve continuous valid cycles
    done_cyc.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) w[k] = 32'(f * 4 + k + 1);
      send_plain(w, f == 2);
    end
    drain();
    check("b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("b2b_gap1", done_cyc[1] - done_cyc[0], 4);
      check("b2b_gap2", done_cyc[2] - done_cyc[1], 4);
    end
    check("b2b_ch_a", ch_a, 9);
    check("b2b_ch_d", ch_d, 12);

    // Reset asserted after word 2 of a frame
    @(negedge clk); valid = 1'b1; ad_ch_in = 32'h0555;
    @(negedge clk); valid = 1'b1; ad_ch_in = 32'h0666;
    @(negedge clk); rst_n = 1'b0; valid = 1'b0; ad_ch_in = 'x;
    #1;
    check("midrst_ch_a", ch_a, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    check("midrst_flags", {done, short_err}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_fcnt = '0;
    m_ecnt = '0;
    send_plain({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    drain();
    check("post_rst_frame_cnt", frame_cnt, 1);

    // err_cnt saturation
    for (int i = 0; i < 256; i++) send({32'h0, 32'h0, 32'h0, 32'(i)}, 1, 1'b1, 0, 0, 0, 0, 1'b0);
    drain();
    check("err_sat", err_cnt, 8'hFF);

    // frame_cnt wrap
    n_wrap = (1 << FW) - int'(m_fcnt);
    for (int f = 0; f < n_wrap; f++) begin
      for (int k = 0; k < 4; k++) w[k] = 32'($urandom_range(0, 4095));
      send_plain(w, f == n_wrap - 1);
    end
    drain();
    check("frame_wrap", frame_cnt, 0);
    check("err_still_sat", err_cnt, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
